// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR test traffic generator.
// Holds the run-state encoding, the PRBS31 polynomial taps and the
// default generator seed used by the top level and the PRBS sub-module.
package ddr_test_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WAIT_CAL = 4'd1,
      WR       = 4'd2,
      RD       = 4'd3,
      DRAIN    = 4'd4,
      DONE     = 4'd5
   } state_e;

   // x^31 + x^28 + 1 : feedback taps as bit indices of the 31-bit register
   localparam int          PRBS_TAP_A        = 30;
   localparam int          PRBS_TAP_B        = 27;
   localparam logic [30:0] PRBS_SEED_DEFAULT = 31'h7FFF_FFFF;

endpackage

// File: rtl/ddr_test_prbs64.sv
// PRBS31 word generator: produces W sequence bits per step.
// The first bit produced in a step lands in data[W-1].
// Ports:
//   s_axi_aclk, s_axi_aresetn : clock, async active-low reset (loads SEED)
//   load                      : restart the sequence from SEED
//   step                      : advance to the next W-bit word
//   data                      : current word (registered)
module ddr_test_prbs64
   import ddr_test_pkg::*;
#(
   parameter int          W    = 64,
   parameter logic [30:0] SEED = PRBS_SEED_DEFAULT
) (
   input  logic         s_axi_aclk,
   input  logic         s_axi_aresetn,
   input  logic         load,
   input  logic         step,
   output logic [W-1:0] data
);

   // Returns {word, register state after producing that word}.
   function automatic logic [W+30:0] advance(input logic [30:0] st_in);
      logic [30:0]  st;
      logic [W-1:0] w;
      logic         nb;
      st = st_in;
      w  = '0;
      for (int i = 0; i < W; i++) begin
         nb         = st[PRBS_TAP_A] ^ st[PRBS_TAP_B];
         st         = {st[29:0], nb};
         w[W-1-i]   = nb;
      end
      return {w, st};
   endfunction

   localparam logic [W+30:0] SEED_WORD = advance(SEED);

   logic [30:0]   lfsr;
   logic [W+30:0] next_word;

   assign next_word = advance(lfsr);

   // data always holds the word for the current beat; lfsr holds the
   // register state just past it, so a step is a single register update.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         {data, lfsr} <= SEED_WORD;
      end else if (load) begin
         {data, lfsr} <= SEED_WORD;
      end else if (step) begin
         {data, lfsr} <= next_word;
      end
   end

endmodule

// File: rtl/ddr_test_traffic_gen.sv
// DDR memory BIST traffic generator.
// A rising edge of prbs_mode_start runs: wait for calibration, write req_len
// beats from BASE_ADDR, read them back with at most MAX_OUT reads in flight,
// and compare every returned beat against an independently regenerated
// pattern (PRBS31 or alternating zeros/ones).
// Ports:
//   s_axi_aclk, s_axi_aresetn          : clock, async active-low reset
//   prbs_mode_start/sel, req_len       : run trigger, pattern select, beats
//   ddr_cal_done                       : memory calibrated
//   mem_cmd_valid/ready/wr/addr, mem_wdata : command channel
//   mem_rdata_valid, mem_rdata         : in-order read return
//   bist_running, bist_cplt, err       : status, {sticky flag, mismatch count}
//   wr_cnt, rd_req_cnt, rd_back_cnt    : progress counters
//   round_time, curr_state             : run duration, state encoding
module ddr_test_traffic_gen
   import ddr_test_pkg::*;
#(
   parameter int                ADDR_W    = 34,
   parameter int                DATA_W    = 64,
   parameter int                MAX_OUT   = 64,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter logic [30:0]       SEED      = PRBS_SEED_DEFAULT
) (
   input  logic              s_axi_aclk,
   input  logic              s_axi_aresetn,
   input  logic              prbs_mode_start,
   input  logic              prbs_mode_sel,
   input  logic [31:0]       req_len,
   input  logic              ddr_cal_done,
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic              mem_cmd_wr,
   output logic [ADDR_W-1:0] mem_cmd_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rdata_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              bist_running,
   output logic              bist_cplt,
   output logic [32:0]       err,
   output logic [31:0]       wr_cnt,
   output logic [31:0]       rd_req_cnt,
   output logic [31:0]       rd_back_cnt,
   output logic [63:0]       round_time,
   output logic [3:0]        curr_state
);

   localparam logic [31:0] MAX_OUT_W = 32'(MAX_OUT);

   function automatic logic [ADDR_W-1:0] beat_addr(input logic [31:0] idx);
      return BASE_ADDR + ADDR_W'({idx, 3'b000});
   endfunction

   state_e              state_q, state_d;
   logic                start_q;
   logic [31:0]         len_q;
   logic                sel_q;

   logic                run_start, wr_acc, rd_acc, rd_ret, mismatch, gen_step;
   logic [DATA_W-1:0]   gen_data, chk_data, exp_word;

   logic [31:0]         wr_cnt_d, rd_req_d, rd_back_d;
   logic [32:0]         err_d;
   logic [63:0]         round_time_d;
   logic                cmd_valid_d, cmd_wr_d;
   logic [ADDR_W-1:0]   cmd_addr_d;
   logic [DATA_W-1:0]   wdata_d;

   assign curr_state = state_q;

   assign run_start = prbs_mode_start & ~start_q &
                      ((state_q == IDLE) | (state_q == DONE));
   assign wr_acc    = mem_cmd_valid & mem_cmd_ready &  mem_cmd_wr;
   assign rd_acc    = mem_cmd_valid & mem_cmd_ready & ~mem_cmd_wr;
   assign rd_ret    = mem_rdata_valid & ((state_q == RD) | (state_q == DRAIN));
   assign exp_word  = sel_q ? chk_data : {DATA_W{rd_back_cnt[0]}};
   assign mismatch  = rd_ret & (mem_rdata != exp_word);

   // The write generator runs one beat ahead of mem_wdata so the next
   // beat's word is ready the moment the current write is accepted.
   ddr_test_prbs64 #(.W(DATA_W), .SEED(SEED)) u_gen (
      .s_axi_aclk    (s_axi_aclk),
      .s_axi_aresetn (s_axi_aresetn),
      .load          (run_start),
      .step          (gen_step),
      .data          (gen_data)
   );

   ddr_test_prbs64 #(.W(DATA_W), .SEED(SEED)) u_chk (
      .s_axi_aclk    (s_axi_aclk),
      .s_axi_aresetn (s_axi_aresetn),
      .load          (run_start),
      .step          (rd_ret),
      .data          (chk_data)
   );

   always_comb begin
      state_d      = state_q;
      wr_cnt_d     = wr_cnt      + {31'd0, wr_acc};
      rd_req_d     = rd_req_cnt  + {31'd0, rd_acc};
      rd_back_d    = rd_back_cnt + {31'd0, rd_ret};
      err_d        = err;
      round_time_d = round_time;
      cmd_valid_d  = 1'b0;
      cmd_wr_d     = 1'b0;
      cmd_addr_d   = mem_cmd_addr;
      wdata_d      = mem_wdata;
      gen_step     = 1'b0;

      if (mismatch)
         err_d = {1'b1, (&err[31:0]) ? err[31:0] : err[31:0] + 32'd1};
      if (bist_running && !(&round_time))
         round_time_d = round_time + 64'd1;

      case (state_q)
         IDLE, DONE: begin
            if (run_start) begin
               state_d      = WAIT_CAL;
               wr_cnt_d     = '0;
               rd_req_d     = '0;
               rd_back_d    = '0;
               err_d        = '0;
               round_time_d = '0;
            end
         end
         WAIT_CAL: begin
            if (ddr_cal_done) begin
               if (len_q == 32'd0) begin
                  state_d = DONE;
               end else begin
                  state_d     = WR;
                  cmd_valid_d = 1'b1;
                  cmd_wr_d    = 1'b1;
                  cmd_addr_d  = beat_addr(32'd0);
                  wdata_d     = sel_q ? gen_data : '0;
                  gen_step    = 1'b1;
               end
            end
         end
         WR: begin
            if (wr_acc && wr_cnt_d == len_q) begin
               state_d     = RD;
               cmd_valid_d = 1'b1;
               cmd_addr_d  = beat_addr(32'd0);
            end else begin
               cmd_valid_d = 1'b1;
               cmd_wr_d    = 1'b1;
               if (wr_acc) begin
                  cmd_addr_d = beat_addr(wr_cnt_d);
                  wdata_d    = sel_q ? gen_data : {DATA_W{wr_cnt_d[0]}};
                  gen_step   = 1'b1;
               end
            end
         end
         RD: begin
            if (rd_acc && rd_req_d == len_q) begin
               state_d = DRAIN;
            end else begin
               // Counts used here are next-cycle values, so the window
               // limit applies to the very cycle the command is shown.
               cmd_valid_d = (rd_req_d - rd_back_d) < MAX_OUT_W;
               cmd_addr_d  = beat_addr(rd_req_d);
            end
         end
         DRAIN: begin
            if (rd_back_d == len_q)
               state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q       <= IDLE;
         // Held high so a start level present at reset release is not an edge.
         start_q       <= 1'b1;
         len_q         <= '0;
         sel_q         <= 1'b0;
         wr_cnt        <= '0;
         rd_req_cnt    <= '0;
         rd_back_cnt   <= '0;
         err           <= '0;
         round_time    <= '0;
         mem_cmd_valid <= 1'b0;
         mem_cmd_wr    <= 1'b0;
         mem_cmd_addr  <= '0;
         mem_wdata     <= '0;
         bist_running  <= 1'b0;
         bist_cplt     <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_q       <= prbs_mode_start;
         if (run_start) begin
            len_q <= req_len;
            sel_q <= prbs_mode_sel;
         end
         wr_cnt        <= wr_cnt_d;
         rd_req_cnt    <= rd_req_d;
         rd_back_cnt   <= rd_back_d;
         err           <= err_d;
         round_time    <= round_time_d;
         mem_cmd_valid <= cmd_valid_d;
         mem_cmd_wr    <= cmd_wr_d;
         mem_cmd_addr  <= cmd_addr_d;
         mem_wdata     <= wdata_d;
         bist_running  <= (state_d == WAIT_CAL) | (state_d == WR) |
                          (state_d == RD) | (state_d == DRAIN);
         bist_cplt     <= (state_d == DONE);
      end
   end

endmodule

// File: doc/ddr_test_traffic_gen.md
DDR_TEST_TRAFFIC_GEN -- requirements
Module: ddr_test_traffic_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 34, meaning the memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 64, meaning the beat width; 8 bytes per beat.
REQ-003 SHALL have parameter MAX_OUT, default 64, meaning the maximum number of outstanding reads.
REQ-004 SHALL have parameter BASE_ADDR, default 0, meaning the start byte address.
REQ-005 SHALL have parameter SEED, default 31'h7FFF_FFFF, meaning the PRBS31 seed.
REQ-006 SHALL provide these ports, clock and reset first:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  reset, asynchronous, active-low.
- prbs_mode_start  in  1  level input; a rising edge starts a run.
- prbs_mode_sel  in  1  0 = fixed pattern, 1 = PRBS31.
- req_len  in  32  number of beats per run.
- ddr_cal_done  in  1  DDR calibration complete.
- mem_cmd_valid / mem_cmd_ready  out / in  1  command handshake.
- mem_cmd_wr  out  1  1 = write command.
- mem_cmd_addr  out  ADDR_W  byte address.
- mem_wdata  out  DATA_W  write data, valid with the write command.
- mem_rdata_valid  in  1  read data beat; returns are in order, with no backpressure.
- mem_rdata  in  DATA_W  read data.
- bist_running  out  1  run in progress.
- bist_cplt  out  1  run finished.
- err  out  33  {sticky error flag, saturating mismatch count[31:0]}.
- wr_cnt / rd_req_cnt / rd_back_cnt  out  32 each  accepted writes / accepted reads / returned beats.
- round_time  out  64  cycles from start to DONE.
- curr_state  out  4  state encoding.

Function
REQ-007 SHALL implement the states IDLE, WAIT_CAL, WR, RD, DRAIN and DONE.
REQ-008 SHALL detect the start edge by registering prbs_mode_start; a rising edge in IDLE or DONE enters WAIT_CAL.
REQ-009 SHALL ignore start edges seen in WAIT_CAL, WR, RD or DRAIN.
REQ-010 SHALL, on a start edge:
- clear all counters, err and round_time;
- reseed both PRBS generators to SEED;
- latch req_len and prbs_mode_sel for the whole run.
REQ-011 SHALL, in WAIT_CAL, move to WR when ddr_cal_done=1; if the latched length is 0, it SHALL move directly to DONE.
REQ-012 SHALL, in WR, hold mem_cmd_valid=1 and mem_cmd_wr=1, with mem_cmd_addr = BASE_ADDR + (wr_cnt<<3).
REQ-013 SHALL keep the command stable while mem_cmd_valid=1 and mem_cmd_ready=0.
REQ-014 SHALL count a write only on valid&&ready; after the last write is accepted, it SHALL enter RD on the next cycle.
REQ-015 SHALL, in RD, issue reads with mem_cmd_wr=0 and addr = BASE_ADDR + (rd_req_cnt<<3).
REQ-016 SHALL deassert mem_cmd_valid whenever rd_req_cnt - rd_back_cnt == MAX_OUT.
REQ-017 SHALL, after the last read is accepted, enter DRAIN, and leave DRAIN for DONE when rd_back_cnt equals the latched length.
REQ-018 SHALL generate data as follows:
- PRBS31 (x^31+x^28+1) advances DATA_W bits per accepted beat;
- the fixed pattern is all-zeros on even beat indices and all-ones on odd beat indices.
REQ-019 SHALL regenerate the expected data with an independent checker generator, advanced once per mem_rdata_valid.
REQ-020 SHALL count a mismatch when mem_rdata != expected: it SHALL set err[32] and increment err[31:0], saturating at 32'hFFFF_FFFF.
REQ-021 SHALL ignore mem_rdata_valid outside RD and DRAIN, with no counter or err change.
REQ-022 SHALL count a return in the same cycle as a read acceptance correctly, with both counters incrementing.
REQ-023 SHALL hold bist_running=1 in WAIT_CAL, WR, RD and DRAIN.
REQ-024 SHALL hold bist_cplt=1 in DONE until the next start edge.
REQ-025 SHALL increment round_time every cycle while bist_running=1, saturating at all-ones.
REQ-026 SHALL register every output, with mem_cmd_valid never asserted outside WR and RD.

Reset
REQ-027 SHALL, on s_axi_aresetn=0 at any time (including mid-run), force IDLE and zero every output and counter, and load both generators with SEED.
REQ-028 SHALL NOT start a run after reset release unless a new rising edge of prbs_mode_start occurs, so a level already high at release does not start a run.

Structure
REQ-029 SHALL place the state enum, the PRBS31 taps and the SEED default in the shared package ddr_test_pkg.
REQ-030 SHALL implement the PRBS as sub-module ddr_test_prbs64 (load, step, 64-bit parallel output), instantiated twice: once as generator and once as checker.

Verification
REQ-031 SHALL cover a PRBS run: req_len=16, sel=1, ready tied 1, loopback memory -> wr_cnt=rd_req_cnt=rd_back_cnt=16, err=0, bist_cplt=1.
REQ-032 SHALL cover error injection: flip bit 5 of beat 3, req_len=8 -> err={1'b1, 32'd1}.
REQ-033 SHALL cover backpressure: random mem_cmd_ready at 30%, read latency 100 cycles, MAX_OUT=4 -> outstanding never exceeds 4 and the command is stable while stalled.
REQ-034 SHALL cover zero length: req_len=0 -> DONE with no mem_cmd_valid and all counts 0.
REQ-035 SHALL cover calibration gating and reset: ddr_cal_done=0 for 50 cycles -> remains in WAIT_CAL; then reset asserted mid-WR -> all outputs 0 and state IDLE.
REQ-036 SHALL cover restart and ignored starts: a start edge during RD is ignored; a start edge in DONE clears the counters and reruns to identical counts.
